// File: rtl/fft_arb_pkg.sv
// Shared constants and types for the two-requester FFT frame arbiter.
// Frame size, data width, tag depth, FSM encoding and owner tag.
package fft_arb_pkg;

   localparam int N_POINTS  = 16;
   localparam int DATA_W    = 16;
   localparam int TAG_DEPTH = 2;
   localparam int CNT_W     = $clog2(N_POINTS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   typedef logic tag_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// Small FIFO of frame-owner tags, one entry per admitted frame.
// Head is the owner of the oldest frame still returning from the core.
module fft_tag_fifo
   import fft_arb_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  tag_t din,
   input  logic pop,
   output logic full,
   output logic empty,
   output tag_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (occ == OCC_W'(DEPTH));
   assign empty   = (occ == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage, pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
      end
   end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Frame-granular sharing of one FFT core between two requesters.
// Input side is a combinational grant mux; results are routed by tag.
module fft_frame_arbiter
   import fft_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_push,
   input  logic [DATA_W-1:0] req0_real,
   input  logic [DATA_W-1:0] req0_imag,
   output logic              req0_stall,
   input  logic              req1_push,
   input  logic [DATA_W-1:0] req1_real,
   input  logic [DATA_W-1:0] req1_imag,
   output logic              req1_stall,
   output logic              fft_in_push,
   output logic [DATA_W-1:0] fft_in_real,
   output logic [DATA_W-1:0] fft_in_imag,
   input  logic              fft_in_stall,
   input  logic              fft_out_push,
   input  logic [DATA_W-1:0] fft_out_real,
   input  logic [DATA_W-1:0] fft_out_imag,
   output logic              fft_out_stall,
   output logic              rsp0_push,
   output logic [DATA_W-1:0] rsp0_real,
   output logic [DATA_W-1:0] rsp0_imag,
   input  logic              rsp0_stall,
   output logic              rsp1_push,
   output logic [DATA_W-1:0] rsp1_real,
   output logic [DATA_W-1:0] rsp1_imag,
   input  logic              rsp1_stall,
   output logic              err_orphan
);

   arb_state_t       state;
   arb_state_t       state_nxt;
   tag_t             last;
   tag_t             cur_tag;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic             in_xfer;
   logic             in_done;
   logic             out_xfer;
   logic             tag_pop;
   logic             tag_full;
   logic             tag_empty;
   tag_t             tag_head;

   assign cur_tag = (state == GNT1);
   assign in_done = in_xfer && (in_cnt == CNT_W'(N_POINTS - 1));

   fft_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tags (
      .clk   (clk),
      .reset (reset),
      .push  (in_done),
      .din   (cur_tag),
      .pop   (tag_pop),
      .full  (tag_full),
      .empty (tag_empty),
      .head  (tag_head)
   );

   // Grant decision and combinational input mux for the owning requester
   always_comb begin
      state_nxt   = state;
      req0_stall  = 1'b1;
      req1_stall  = 1'b1;
      fft_in_push = 1'b0;
      fft_in_real = '0;
      fft_in_imag = '0;
      in_xfer     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!tag_full && (req0_push || req1_push)) begin
               if (req0_push && req1_push) begin
                  state_nxt = last ? GNT0 : GNT1;
               end else begin
                  state_nxt = req0_push ? GNT0 : GNT1;
               end
            end
         end
         GNT0: begin
            fft_in_push = req0_push;
            fft_in_real = req0_real;
            fft_in_imag = req0_imag;
            req0_stall  = fft_in_stall;
            in_xfer     = req0_push && !fft_in_stall;
         end
         GNT1: begin
            fft_in_push = req1_push;
            fft_in_real = req1_real;
            fft_in_imag = req1_imag;
            req1_stall  = fft_in_stall;
            in_xfer     = req1_push && !fft_in_stall;
         end
         default: state_nxt = IDLE;
      endcase
      if (in_done) begin
         state_nxt = IDLE;
      end
   end

   // Grant state, round-robin memory and input sample count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         last   <= 1'b1;
         in_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (in_done) begin
            last   <= cur_tag;
            in_cnt <= '0;
         end else if (in_xfer) begin
            in_cnt <= in_cnt + 1'b1;
         end
      end
   end

   // Core output back-pressure follows the owner of the head frame
   always_comb begin
      fft_out_stall = 1'b1;
      if (!tag_empty) begin
         fft_out_stall = tag_head ? rsp1_stall : rsp0_stall;
      end
      out_xfer = fft_out_push && !fft_out_stall;
      tag_pop  = out_xfer && (out_cnt == CNT_W'(N_POINTS - 1));
   end

   // Registered result routing, output count and sticky orphan flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp0_push  <= 1'b0;
         rsp0_real  <= '0;
         rsp0_imag  <= '0;
         rsp1_push  <= 1'b0;
         rsp1_real  <= '0;
         rsp1_imag  <= '0;
         out_cnt    <= '0;
         err_orphan <= 1'b0;
      end else begin
         rsp0_push <= out_xfer && !tag_head;
         rsp1_push <= out_xfer && tag_head;
         if (out_xfer && !tag_head) begin
            rsp0_real <= fft_out_real;
            rsp0_imag <= fft_out_imag;
         end
         if (out_xfer && tag_head) begin
            rsp1_real <= fft_out_real;
            rsp1_imag <= fft_out_imag;
         end
         if (tag_pop) begin
            out_cnt <= '0;
         end else if (out_xfer) begin
            out_cnt <= out_cnt + 1'b1;
         end
         if (fft_out_push && tag_empty) begin
            err_orphan <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: emulates requesters and the FFT core,
// predicts every output from a frame-level model with queues.
module tb_fft_frame_arbiter;
   import fft_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        r_push [2];
   logic [15:0] r_re [2];
   logic [15:0] r_im [2];
   logic        rsp_st [2];
   logic        fft_in_stall;
   logic        fft_out_push;
   logic [15:0] fft_out_real;
   logic [15:0] fft_out_imag;
   logic        req0_stall, req1_stall;
   logic        fft_in_push, fft_out_stall;
   logic [15:0] fft_in_real, fft_in_imag;
   logic        rsp0_push, rsp1_push, err_orphan;
   logic [15:0] rsp0_real, rsp0_imag, rsp1_real, rsp1_imag;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   // frame-level model
   int          m_own, m_ic, m_oc, m_last;
   int          m_tags [$];
   bit          m_err;
   bit          m_rp [2];
   logic [31:0] core_q [$];
   logic [31:0] eq0 [$];
   logic [31:0] eq1 [$];
   int          c_ready;

   // measurements taken from the DUT
   int d_in0, d_in1, d_out, n_rsp0, n_rsp1;
   int t_last0, t_first1, t_pop, t_gnt0b, first_own;
   logic [31:0] last_rsp0;

   always #5 clk = ~clk;

   fft_frame_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .req0_push     (r_push[0]),
      .req0_real     (r_re[0]),
      .req0_imag     (r_im[0]),
      .req0_stall    (req0_stall),
      .req1_push     (r_push[1]),
      .req1_real     (r_re[1]),
      .req1_imag     (r_im[1]),
      .req1_stall    (req1_stall),
      .fft_in_push   (fft_in_push),
      .fft_in_real   (fft_in_real),
      .fft_in_imag   (fft_in_imag),
      .fft_in_stall  (fft_in_stall),
      .fft_out_push  (fft_out_push),
      .fft_out_real  (fft_out_real),
      .fft_out_imag  (fft_out_imag),
      .fft_out_stall (fft_out_stall),
      .rsp0_push     (rsp0_push),
      .rsp0_real     (rsp0_real),
      .rsp0_imag     (rsp0_imag),
      .rsp0_stall    (rsp_st[0]),
      .rsp1_push     (rsp1_push),
      .rsp1_real     (rsp1_real),
      .rsp1_imag     (rsp1_imag),
      .rsp1_stall    (rsp_st[1]),
      .err_orphan    (err_orphan)
   );

   function automatic logic [31:0] xf(input logic [31:0] s);
      return {s[31:16] + 16'h0101, s[15:0] ^ 16'h5A5A};
   endfunction

   function automatic bit m_ostall();
      if (m_tags.size() == 0) return 1'b1;
      return rsp_st[m_tags[0]];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit p0, input bit p1, input bit ist,
                        input bit s0, input bit s1, input bit cw,
                        input bit orph, input logic [15:0] d0,
                        input logic [15:0] d1);
      r_push[0] = p0;
      r_push[1] = p1;
      r_re[0] = d0;
      r_im[0] = ~d0;
      r_re[1] = d1;
      r_im[1] = ~d1;
      fft_in_stall = ist;
      rsp_st[0] = s0;
      rsp_st[1] = s1;
      if (orph) begin
         fft_out_push = 1'b1;
         fft_out_real = 16'hdead;
         fft_out_imag = 16'hbeef;
      end else if (cw && c_ready > 0 && !m_ostall()) begin
         fft_out_push = 1'b1;
         {fft_out_real, fft_out_imag} = xf(core_q[0]);
      end else begin
         fft_out_push = 1'b0;
         fft_out_real = '0;
         fft_out_imag = '0;
      end
   endtask

   task automatic step();
      bit ers0, ers1, eip, eos, in_x, out_x, orph, gnt;
      logic [31:0] s;
      int h;
      #1;
      cyc++;
      ers0 = 1'b1;
      ers1 = 1'b1;
      eip  = 1'b0;
      if (m_own == 0) begin ers0 = fft_in_stall; eip = r_push[0]; end
      if (m_own == 1) begin ers1 = fft_in_stall; eip = r_push[1]; end
      eos = m_ostall();
      chk("req0_stall", 32'(req0_stall), 32'(ers0));
      chk("req1_stall", 32'(req1_stall), 32'(ers1));
      chk("fft_in_push", 32'(fft_in_push), 32'(eip));
      if (eip)
         chk("fft_in_data", {fft_in_real, fft_in_imag},
             {r_re[m_own], r_im[m_own]});
      chk("fft_out_stall", 32'(fft_out_stall), 32'(eos));
      chk("rsp0_push", 32'(rsp0_push), 32'(m_rp[0]));
      chk("rsp1_push", 32'(rsp1_push), 32'(m_rp[1]));
      chk("err_orphan", 32'(err_orphan), 32'(m_err));
      if (rsp0_push) begin
         chk("rsp0_avail", 32'(eq0.size() > 0), 32'd1);
         if (eq0.size() > 0)
            chk("rsp0_data", {rsp0_real, rsp0_imag}, eq0.pop_front());
         n_rsp0++;
         last_rsp0 = {rsp0_real, rsp0_imag};
      end
      if (rsp1_push) begin
         chk("rsp1_avail", 32'(eq1.size() > 0), 32'd1);
         if (eq1.size() > 0)
            chk("rsp1_data", {rsp1_real, rsp1_imag}, eq1.pop_front());
         n_rsp1++;
      end
      if (fft_in_push && !fft_in_stall) begin
         if (first_own < 0) first_own = req0_stall ? 1 : 0;
         if (!req0_stall) begin
            d_in0++;
            if (d_in0 == 16) t_last0 = cyc;
            if (d_in0 == 17) t_gnt0b = cyc;
         end else if (!req1_stall) begin
            if (d_in1 == 0) t_first1 = cyc;
            d_in1++;
         end
      end
      if (fft_out_push && !fft_out_stall) begin
         d_out++;
         if (d_out == 16) t_pop = cyc;
      end
      // advance the model by one clock
      in_x = 1'b0;
      if (m_own >= 0) in_x = r_push[m_own] && !fft_in_stall;
      gnt = (m_own < 0) && (m_tags.size() < TAG_DEPTH) &&
            (r_push[0] || r_push[1]);
      out_x = fft_out_push && !eos;
      orph  = fft_out_push && (m_tags.size() == 0);
      m_rp[0] = 1'b0;
      m_rp[1] = 1'b0;
      if (orph) m_err = 1'b1;
      if (out_x) begin
         h = m_tags[0];
         m_rp[h] = 1'b1;
         void'(core_q.pop_front());
         c_ready--;
         m_oc++;
         if (m_oc == N_POINTS) begin
            m_oc = 0;
            void'(m_tags.pop_front());
         end
      end
      if (in_x) begin
         s = {r_re[m_own], r_im[m_own]};
         core_q.push_back(s);
         if (m_own == 0) eq0.push_back(xf(s));
         else eq1.push_back(xf(s));
         m_ic++;
         if (m_ic == N_POINTS) begin
            m_ic = 0;
            m_tags.push_back(m_own);
            m_last = m_own;
            m_own = -1;
            c_ready += N_POINTS;
         end
      end else if (gnt) begin
         if (r_push[0] && r_push[1]) m_own = 1 - m_last;
         else m_own = r_push[0] ? 0 : 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      c_ready = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req0_stall", 32'(req0_stall), 32'd1);
      chk("rst_req1_stall", 32'(req1_stall), 32'd1);
      chk("rst_fft_in_push", 32'(fft_in_push), 32'd0);
      chk("rst_fft_out_stall", 32'(fft_out_stall), 32'd1);
      chk("rst_rsp_push", {30'd0, rsp1_push, rsp0_push}, 32'd0);
      chk("rst_rsp0_data", {rsp0_real, rsp0_imag}, 32'd0);
      chk("rst_rsp1_data", {rsp1_real, rsp1_imag}, 32'd0);
      chk("rst_err_orphan", 32'(err_orphan), 32'd0);
      m_own = -1; m_ic = 0; m_oc = 0; m_last = 1; m_err = 1'b0;
      m_rp[0] = 1'b0; m_rp[1] = 1'b0;
      m_tags.delete(); core_q.delete(); eq0.delete(); eq1.delete();
      d_in0 = 0; d_in1 = 0; d_out = 0; n_rsp0 = 0; n_rsp1 = 0;
      t_last0 = 0; t_first1 = 0; t_pop = 0; t_gnt0b = 0;
      first_own = -1; last_rsp0 = '0;
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k;
      bit adv;
      // single requester frame 0..15 and its return
      do_reset();
      k = 0;
      for (int i = 0; i < 40 && k < 16; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 16'(k), 16'h0);
         adv = (m_own == 0);
         step();
         if (adv) k++;
      end
      repeat (24) begin
         drive(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
         step();
      end
      chk("t1_rsp0_count", n_rsp0, 16);
      chk("t1_rsp1_count", n_rsp1, 0);
      chk("t1_last_rsp0", last_rsp0, 32'h0110A5AA);

      // both request from reset; then fifo full with req0 waiting
      do_reset();
      for (int i = 0; i < 60 && m_tags.size() < 2; i++) begin
         drive(1, 1, 0, 0, 0, 0, 0, 16'($urandom), 16'($urandom));
         step();
      end
      chk("t2_first_owner", first_own, 0);
      chk("t2_req1_gap", t_first1 - t_last0, 2);
      for (int j = 0; j < 100 && d_in0 < 17; j++) begin
         drive(1, 0, 0, (j >= 5 && j < 9), 0, (j >= 3), 0,
               16'($urandom), 16'h0);
         step();
      end
      chk("t3_regrant_gap", t_gnt0b - t_pop, 2);
      chk("t3_rsp0_frame", n_rsp0, 16);

      // orphan sample from the core
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      step();
      repeat (3) begin
         drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
         step();
      end
      chk("t5_err_orphan", 32'(err_orphan), 32'd1);
      chk("t5_rsp_count", n_rsp0 + n_rsp1, 0);

      // reset in the middle of a req1 frame, then contention
      do_reset();
      for (int i = 0; i < 20 && !(m_own == 1 && m_ic == 7); i++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'($urandom));
         step();
      end
      do_reset();
      drive(1, 1, 0, 0, 0, 0, 0, 16'h1111, 16'h2222);
      step();
      drive(1, 1, 0, 0, 0, 0, 0, 16'h3333, 16'h4444);
      #1;
      chk("t6_gnt0_req0", 32'(req0_stall), 32'd0);
      chk("t6_gnt0_req1", 32'(req1_stall), 32'd1);
      step();

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, 0,
               16'($urandom), 16'($urandom));
         step();
      end
      repeat (200) begin
         drive(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
         step();
      end
      chk("rand_rsp_seen", 32'(n_rsp0 > 0 && n_rsp1 > 0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
